// File: rtl/bch_chien_search_serial_pkg.sv
// rtl/bch_chien_search_serial_pkg.sv - shared BCH field parameters, types and GF(2^m) helpers
package bch_chien_search_serial_pkg;

   localparam int M      = 4;
   localparam int D      = 7;
   localparam int T      = (D - 1) / 2;
   localparam int IRRPOL = 19;
   localparam int PTR_W  = 2;
   localparam int NUM_W  = $clog2(T + 1);
   localparam int GF_Q   = (1 << M) - 1;

   typedef logic [M-1:0]     data_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [NUM_W-1:0] num_t;

   localparam data_t IRR_LOW = data_t'(IRRPOL);

   function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
      data_t p;
      data_t aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[M-1] ? ({aa[M-2:0], 1'b0} ^ IRR_LOW) : {aa[M-2:0], 1'b0};
      end
      return p;
   endfunction

   function automatic data_t gf_alpha_pow(input int e);
      data_t r;
      r = data_t'(1);
      for (int i = 0; i < e % GF_Q; i++) r = gf_mult_a_by_b(r, data_t'(2));
      return r;
   endfunction

endpackage

// File: rtl/bch_chien_search_serial_if.sv
// rtl/bch_chien_search_serial_if.sv - locator polynomial input and error flag stream bundle
interface bch_chien_search_serial_if;
   import bch_chien_search_serial_pkg::*;

   logic  iloc_poly_val;
   data_t iloc_poly [0:T];
   ptr_t  iloc_poly_ptr;
   logic  iloc_decfail;
   logic  ordy;
   logic  oerr_val;
   logic  oerr_sop;
   logic  oerr_eop;
   logic  oerr;
   ptr_t  oerr_ptr;
   num_t  oerr_num;
   logic  odecfail;

   modport slave (
      input  iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_decfail,
      output ordy, oerr_val, oerr_sop, oerr_eop, oerr, oerr_ptr, oerr_num, odecfail
   );

   modport master (
      output iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_decfail,
      input  ordy, oerr_val, oerr_sop, oerr_eop, oerr, oerr_ptr, oerr_num, odecfail
   );

endinterface

// File: rtl/bch_chien_search_serial_cell.sv
// rtl/bch_chien_search_serial_cell.sv - one Chien term: pre-scaled load, then constant alpha^i step
module bch_chien_cell
   import bch_chien_search_serial_pkg::*;
#(
   parameter data_t SCALE = '0,
   parameter data_t STEP  = '0
) (
   input  logic  iclk,
   input  logic  iload,
   input  logic  ien,
   input  data_t icoef,
   output data_t ocoef
);

   data_t coef_q;

   always_ff @(posedge iclk) begin
      if (iload) begin
         coef_q <= gf_mult_a_by_b(icoef, SCALE);
      end else if (ien) begin
         coef_q <= gf_mult_a_by_b(coef_q, STEP);
      end
   end

   assign ocoef = coef_q;

endmodule

// File: rtl/bch_chien_search_serial.sv
// rtl/bch_chien_search_serial.sv - serial Chien search, one codeword position per clock, n-1 first
module bch_chien_search_serial
   import bch_chien_search_serial_pkg::*;
#(
   parameter int n = 15
) (
   input logic                      iclk,
   input logic                      ireset_n,
   bch_chien_search_serial_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam int POS_W = $clog2(n + 1);
   localparam logic [POS_W-1:0] POS_TOP = POS_W'(n - 1);
   localparam num_t T_NUM = num_t'(T);

   logic [0:0]       state;
   logic [POS_W-1:0] pos;
   ptr_t             ptr_q, oerr_ptr_q;
   logic             decfail_q, zero_q;
   num_t             deg_q, cnt_q, oerr_num_q;
   logic             val_q, sop_q, eop_q, err_q, odecfail_q;

   logic  accept, run, root, hit, last, zero_in;
   num_t  deg_in, cnt_next;
   data_t sum;
   data_t coef [0:T];

   assign accept = bus.iloc_poly_val & (state == ST_IDLE);
   assign run    = (state == ST_RUN);

   // Load scaling alpha^(i*(2^m-n)) makes the first evaluated point alpha^-(n-1).
   for (genvar gi = 0; gi <= T; gi++) begin : g_cell
      bch_chien_cell #(
         .SCALE(gf_alpha_pow(gi * (GF_Q - (n - 1)))),
         .STEP (gf_alpha_pow(gi))
      ) u_cell (
         .iclk (iclk),
         .iload(accept),
         .ien  (run),
         .icoef(bus.iloc_poly[gi]),
         .ocoef(coef[gi])
      );
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i <= T; i++) sum = sum ^ coef[i];
      deg_in  = '0;
      zero_in = 1'b1;
      for (int i = 0; i <= T; i++) begin
         if (bus.iloc_poly[i] != '0) begin
            deg_in  = num_t'(i);
            zero_in = 1'b0;
         end
      end
   end

   // An all-zero polynomial "hits" everywhere, so it never counts as a root.
   assign root     = (sum == '0);
   assign hit      = root & ~zero_q;
   assign cnt_next = (hit && cnt_q != T_NUM) ? cnt_q + 1'b1 : cnt_q;
   assign last     = (pos == '0);

   always_ff @(posedge iclk) begin
      if (!ireset_n) begin
         state      <= ST_IDLE;
         pos        <= '0;
         ptr_q      <= '0;
         oerr_ptr_q <= '0;
         decfail_q  <= 1'b0;
         zero_q     <= 1'b0;
         deg_q      <= '0;
         cnt_q      <= '0;
         val_q      <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
         oerr_num_q <= '0;
         odecfail_q <= 1'b0;
      end else begin
         val_q      <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
         oerr_num_q <= '0;
         odecfail_q <= 1'b0;
         if (state == ST_IDLE) begin
            if (accept) begin
               state     <= ST_RUN;
               ptr_q     <= bus.iloc_poly_ptr;
               decfail_q <= bus.iloc_decfail;
               zero_q    <= zero_in;
               deg_q     <= deg_in;
               cnt_q     <= '0;
               pos       <= POS_TOP;
            end
         end else begin
            val_q <= 1'b1;
            sop_q <= (pos == POS_TOP);
            eop_q <= last;
            err_q <= root & ~zero_q & ~decfail_q;
            cnt_q <= cnt_next;
            pos   <= pos - 1'b1;
            if (pos == POS_TOP) oerr_ptr_q <= ptr_q;
            if (last) begin
               oerr_num_q <= cnt_next;
               odecfail_q <= decfail_q | zero_q | (cnt_next != deg_q);
               state      <= ST_IDLE;
            end
         end
      end
   end

   assign bus.ordy     = (state == ST_IDLE);
   assign bus.oerr_val = val_q;
   assign bus.oerr_sop = sop_q;
   assign bus.oerr_eop = eop_q;
   assign bus.oerr     = err_q;
   assign bus.oerr_ptr = oerr_ptr_q;
   assign bus.oerr_num = oerr_num_q;
   assign bus.odecfail = odecfail_q;

endmodule

// File: tb/tb_bch_chien_search_serial.sv
// tb/tb_bch_chien_search_serial.sv - self-checking bench, n=15 and shortened n=10 instances
module tb_bch_chien_search_serial;
   import bch_chien_search_serial_pkg::*;

   logic iclk = 1'b0;
   logic ireset_n;
   always #5 iclk = ~iclk;

   bch_chien_search_serial_if ba();
   bch_chien_search_serial_if bb();

   bch_chien_search_serial #(.n(15)) dut_a (.iclk(iclk), .ireset_n(ireset_n), .bus(ba.slave));
   bch_chien_search_serial #(.n(10)) dut_b (.iclk(iclk), .ireset_n(ireset_n), .bus(bb.slave));

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // GF(16) reference arithmetic via exp/log tables
   int exp_t [0:14];
   int log_t [0:15];

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_t[(log_t[a] + log_t[b]) % 15];
   endfunction

   function automatic void model(input data_t l [0:3], input logic df, input int nn,
                                 output logic [14:0] mask, output int num, output logic dec);
      int roots, deg, s, xp, x, j;
      logic zero;
      roots = 0; deg = 0; zero = 1'b1; mask = '0;
      for (int i = 0; i < 4; i++) if (l[i] != 0) begin zero = 1'b0; deg = i; end
      for (int c = 0; c < nn; c++) begin
         j = nn - 1 - c;
         x = exp_t[(15 - j) % 15];
         s = 0; xp = 1;
         for (int i = 0; i < 4; i++) begin
            s  = s ^ gmul(int'(l[i]), xp);
            xp = gmul(xp, x);
         end
         if (s == 0 && !zero) begin
            roots++;
            mask[c] = !df;
         end
      end
      num = (roots > 3) ? 3 : roots;
      dec = df | zero | (num != deg);
   endfunction

   // Output stream monitor, both instances
   int          cyc = 0;
   int          idx [2];
   logic [14:0] flags [2];
   int          len [2], sop_cyc [2], eop_cyc [2], eop_cnt [2], r_num [2];
   ptr_t        cur_ptr [2];
   logic        ptr_bad [2], got [2], r_dec [2];

   always @(negedge iclk) begin
      logic v [2], s [2], e [2], er [2], dc [2];
      ptr_t p [2];
      num_t nm [2];
      cyc++;
      v[0] = ba.oerr_val; s[0] = ba.oerr_sop; e[0] = ba.oerr_eop; er[0] = ba.oerr;
      dc[0] = ba.odecfail; p[0] = ba.oerr_ptr; nm[0] = ba.oerr_num;
      v[1] = bb.oerr_val; s[1] = bb.oerr_sop; e[1] = bb.oerr_eop; er[1] = bb.oerr;
      dc[1] = bb.odecfail; p[1] = bb.oerr_ptr; nm[1] = bb.oerr_num;
      for (int k = 0; k < 2; k++) begin
         if (v[k] === 1'b1) begin
            if (s[k]) begin
               idx[k] = 0; sop_cyc[k] = cyc; cur_ptr[k] = p[k];
            end else if (p[k] !== cur_ptr[k]) begin
               ptr_bad[k] = 1'b1;
            end
            if (idx[k] >= 0 && idx[k] < 15) flags[k][idx[k]] = er[k];
            idx[k]++;
            if (e[k]) begin
               len[k] = idx[k]; r_num[k] = int'(nm[k]); r_dec[k] = dc[k];
               eop_cyc[k] = cyc; eop_cnt[k]++; got[k] = 1'b1;
            end
         end
      end
   end

   task automatic drive(input int k, input data_t l [0:3], input logic df, input ptr_t p, input logic v);
      if (k == 0) begin
         for (int i = 0; i < 4; i++) ba.iloc_poly[i] = l[i];
         ba.iloc_decfail = df; ba.iloc_poly_ptr = p; ba.iloc_poly_val = v;
      end else begin
         for (int i = 0; i < 4; i++) bb.iloc_poly[i] = l[i];
         bb.iloc_decfail = df; bb.iloc_poly_ptr = p; bb.iloc_poly_val = v;
      end
   endtask

   function automatic logic rdy(input int k);
      return (k == 0) ? ba.ordy : bb.ordy;
   endfunction

   task automatic clear(input int k);
      got[k] = 1'b0; flags[k] = '0; ptr_bad[k] = 1'b0;
   endtask

   task automatic send(input int k, input data_t l [0:3], input logic df, input ptr_t p);
      int b;
      b = 0;
      while (rdy(k) !== 1'b1 && b < 100) begin @(posedge iclk); #1; b++; end
      check("send_ready", rdy(k), 1);
      drive(k, l, df, p, 1'b1);
      @(posedge iclk); #1;
      drive(k, l, df, p, 1'b0);
   endtask

   task automatic wait_got(input int k);
      int b;
      b = 0;
      while (!got[k] && b < 60) begin @(posedge iclk); #1; b++; end
      check("eop_seen", got[k], 1);
   endtask

   task automatic check_word(input int k, input int nn, input logic [14:0] mask,
                             input int num, input logic dec, input ptr_t p);
      check("length", len[k], nn);
      check("err_flags", flags[k], mask);
      check("err_num", r_num[k], num);
      check("decfail", r_dec[k], dec);
      check("ptr", cur_ptr[k], p);
      check("ptr_stable", ptr_bad[k], 0);
   endtask

   typedef struct {
      int          k;
      data_t       l [0:3];
      logic        df;
      logic [14:0] mask;
      int          num;
      logic        dec;
   } vec_t;
   vec_t vecs [$];

   task automatic add_vec(input int k, input int l0, input int l1, input int l2, input int l3,
                          input logic df, input logic [14:0] mask, input int num, input logic dec);
      vec_t v;
      v.k = k; v.df = df; v.mask = mask; v.num = num; v.dec = dec;
      v.l[0] = data_t'(l0); v.l[1] = data_t'(l1); v.l[2] = data_t'(l2); v.l[3] = data_t'(l3);
      vecs.push_back(v);
   endtask

   task automatic gen(output data_t l [0:3]);
      int p [0:3];
      int a, c, e;
      p = '{1, 0, 0, 0};
      e = $urandom_range(0, 3);
      for (int r = 0; r < e; r++) begin
         a = exp_t[$urandom_range(0, 14)];
         for (int i = 3; i >= 1; i--) p[i] = p[i] ^ gmul(p[i-1], a);
      end
      c = exp_t[$urandom_range(0, 14)];
      for (int i = 0; i < 4; i++) l[i] = data_t'(gmul(p[i], c));
      if ($urandom_range(0, 4) == 0)
         for (int i = 0; i < 4; i++) l[i] = data_t'($urandom_range(0, 15));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      data_t       w1 [0:3], w2 [0:3], wr [0:3];
      logic [14:0] mask;
      int          num, v, nn, b, c0, e1;
      logic        dec, df;
      ptr_t        pr;

      v = 1;
      for (int e = 0; e < 15; e++) begin
         exp_t[e] = v; log_t[v] = e;
         v = v << 1;
         if ((v & 16) != 0) v = v ^ 19;
      end
      for (int k = 0; k < 2; k++) begin
         idx[k] = -100; eop_cnt[k] = 0; len[k] = 0; r_num[k] = 0; r_dec[k] = 0;
         cur_ptr[k] = '0; clear(k);
      end
      w1 = '{4'd0, 4'd0, 4'd0, 4'd0};
      drive(0, w1, 1'b0, '0, 1'b0);
      drive(1, w1, 1'b0, '0, 1'b0);

      ireset_n = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      check("rst_ordy_a", ba.ordy, 1);
      check("rst_val_a", ba.oerr_val, 0);
      check("rst_sop_eop_a", {ba.oerr_sop, ba.oerr_eop, ba.oerr}, 0);
      check("rst_num_a", ba.oerr_num, 0);
      check("rst_decfail_a", ba.odecfail, 0);
      check("rst_ordy_b", bb.ordy, 1);
      check("rst_val_b", bb.oerr_val, 0);
      ireset_n = 1'b1;

      add_vec(0, 1, 8, 0, 0, 1'b0, 15'h0800, 1, 1'b0);
      add_vec(0, 1, 7, 6, 0, 1'b0, 15'h4200, 2, 1'b0);
      add_vec(1, 1, 14, 15, 0, 1'b0, 15'h0200, 1, 1'b1);
      add_vec(0, 0, 0, 0, 0, 1'b0, 15'h0000, 0, 1'b1);
      add_vec(0, 4, 0, 0, 0, 1'b0, 15'h0000, 0, 1'b0);
      add_vec(0, 1, 8, 0, 0, 1'b1, 15'h0000, 1, 1'b1);
      add_vec(1, 4, 0, 0, 0, 1'b0, 15'h0000, 0, 1'b0);
      add_vec(1, 0, 0, 0, 0, 1'b1, 15'h0000, 0, 1'b1);
      for (int i = 0; i < vecs.size(); i++) begin
         pr = ptr_t'(i);
         clear(vecs[i].k);
         send(vecs[i].k, vecs[i].l, vecs[i].df, pr);
         wait_got(vecs[i].k);
         check_word(vecs[i].k, vecs[i].k ? 10 : 15, vecs[i].mask, vecs[i].num, vecs[i].dec, pr);
      end

      for (int i = 0; i < 40; i++) begin
         int k;
         k  = i % 2;
         nn = k ? 10 : 15;
         gen(wr);
         df = ($urandom_range(0, 7) == 0);
         pr = ptr_t'($urandom_range(0, 3));
         model(wr, df, nn, mask, num, dec);
         clear(k);
         send(k, wr, df, pr);
         wait_got(k);
         check_word(k, nn, mask, num, dec, pr);
      end

      // back-to-back with valid held high
      w1 = '{4'd1, 4'd8, 4'd0, 4'd0};
      w2 = '{4'd1, 4'd7, 4'd6, 4'd0};
      clear(0);
      b = 0;
      while (ba.ordy !== 1'b1 && b < 100) begin @(posedge iclk); #1; b++; end
      drive(0, w1, 1'b0, 2'd1, 1'b1);
      @(posedge iclk); #1;
      drive(0, w2, 1'b0, 2'd2, 1'b1);
      wait_got(0);
      e1 = eop_cyc[0];
      check_word(0, 15, 15'h0800, 1, 1'b0, 2'd1);
      drive(0, w2, 1'b0, 2'd2, 1'b0);
      clear(0);
      wait_got(0);
      check("b2b_gap", sop_cyc[0] - e1, 2);
      check_word(0, 15, 15'h4200, 2, 1'b0, 2'd2);

      // valid pulse during RUN is ignored
      clear(0);
      send(0, w1, 1'b0, 2'd3);
      repeat (4) begin @(posedge iclk); #1; end
      check("run_ordy_low", ba.ordy, 0);
      drive(0, w2, 1'b1, 2'd0, 1'b1);
      @(posedge iclk); #1;
      drive(0, w2, 1'b1, 2'd0, 1'b0);
      wait_got(0);
      check_word(0, 15, 15'h0800, 1, 1'b0, 2'd3);
      c0 = eop_cnt[0];
      repeat (25) @(posedge iclk);
      #1;
      check("pulse_no_extra_word", eop_cnt[0], c0);

      // reset in the middle of a run
      clear(0);
      send(0, w1, 1'b0, 2'd1);
      b = 0;
      while (idx[0] != 6 && b < 30) begin @(posedge iclk); #1; b++; end
      check("reached_cycle6", idx[0], 6);
      c0 = eop_cnt[0];
      ireset_n = 1'b0;
      @(posedge iclk); #1;
      check("midrst_val", ba.oerr_val, 0);
      check("midrst_ordy", ba.ordy, 1);
      ireset_n = 1'b1;
      repeat (25) @(posedge iclk);
      #1;
      check("midrst_no_eop", eop_cnt[0], c0);
      clear(0);
      send(0, w2, 1'b0, 2'd2);
      wait_got(0);
      check_word(0, 15, 15'h4200, 2, 1'b0, 2'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
